// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and state encoding for the 10-channel TDM link
package tdm_pkg;

    localparam int unsigned N_CH  = 10;
    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - mod-N_CH slot counter with enable, load-to-1 and clear
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load1_i,
    input  logic             clr_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             last_o
);

    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] cnt_d;

    // Clear wins over load, load wins over a plain advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = SEL_W'(1);
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST_SLOT) ? '0 : cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux_1to10.sv
// rtl/tdm_demux_1to10.sv - 1:10 TDM receive demux with SYNC alignment and frame-error detection
module tdm_demux_1to10
    import tdm_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_i,
    input  logic             in_valid_i,
    input  logic             sync_i,
    output logic [SEL_W-1:0] s_o,
    output logic [N_CH-1:0]  out_o,
    output logic             out_valid_o,
    output logic             locked_o,
    output logic             frame_err_o
);

    tdm_state_e        state_q, state_d;
    logic [N_CH-2:0]   shadow_q, shadow_d;
    logic [N_CH-1:0]   out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_err_q, frame_err_d;

    logic [SEL_W-1:0]  slot;
    logic              slot_last;
    logic              cnt_en, cnt_load1, cnt_clr;

    tdm_slot_counter u_slot_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (cnt_en),
        .load1_i (cnt_load1),
        .clr_i   (cnt_clr),
        .cnt_o   (slot),
        .last_o  (slot_last)
    );

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        cnt_en      = 1'b0;
        cnt_load1   = 1'b0;
        cnt_clr     = 1'b0;

        if (in_valid_i) begin
            unique case (state_q)
                HUNT: begin
                    if (sync_i) begin
                        shadow_d[0] = in_i;
                        cnt_load1   = 1'b1;
                        state_d     = LOCK;
                    end
                end
                LOCK: begin
                    if (sync_i) begin
                        // Early SYNC restarts the frame; the partial frame never reaches OUT.
                        shadow_d[0] = in_i;
                        cnt_load1   = 1'b1;
                        frame_err_d = (slot != '0);
                    end else if (slot == '0) begin
                        frame_err_d = 1'b1;
                        cnt_clr     = 1'b1;
                        state_d     = HUNT;
                    end else if (slot_last) begin
                        out_d       = {in_i, shadow_q};
                        out_valid_d = 1'b1;
                        cnt_clr     = 1'b1;
                    end else begin
                        shadow_d[slot] = in_i;
                        cnt_en         = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HUNT;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign s_o         = slot;
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign locked_o    = (state_q == LOCK);
    assign frame_err_o = frame_err_q;

endmodule
